// File: rtl/instr_fetch_ctrl_if.sv
// instr_fetch_ctrl_if: ROM port and decode handshake between the fetch sequencer and its neighbours
interface instr_fetch_ctrl_if #(
    parameter int ADDR_W = 8,
    parameter int DATA_W = 32
);
    logic [ADDR_W-1:0] rom_addr;
    logic [DATA_W-1:0] rom_data;
    logic              instr_valid;
    logic              instr_ready;
    logic [DATA_W-1:0] instr_out;
    logic [ADDR_W-1:0] instr_pc;
    modport master (output rom_addr, instr_valid, instr_out, instr_pc, input rom_data, instr_ready);
    modport slave  (input rom_addr, instr_valid, instr_out, instr_pc, output rom_data, instr_ready);
endinterface

// File: rtl/instr_fetch_ctrl.sv
// instr_fetch_ctrl: sequences ROM fetches, absorbs the ROM read latency and buffers words for decode
module instr_fetch_ctrl #(
    parameter int                ADDR_W    = 8,
    parameter int                DATA_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter int                PC_STEP   = 4,
    parameter int                BUF_DEPTH = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en_i,
    input  logic              redirect_i,
    input  logic [ADDR_W-1:0] redirect_pc_i,
    instr_fetch_ctrl_if.master bus
);
    localparam int CNT_W = $clog2(BUF_DEPTH + 1);
    localparam int PTR_W = $clog2(BUF_DEPTH);

    logic [ADDR_W-1:0] fetch_pc_q, fetch_pc_d, req_pc_q, req_pc_d;
    logic              req_valid_q, req_valid_d;
    logic [CNT_W-1:0]  count_q, count_d;
    logic [PTR_W-1:0]  rd_q, rd_d, wr_q, wr_d;
    logic [ADDR_W-1:0] pc_mem_q [BUF_DEPTH];
    logic [DATA_W-1:0] data_mem_q [BUF_DEPTH];
    logic              pop, push, issue;

    function automatic logic [PTR_W-1:0] nxt(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(BUF_DEPTH - 1)) ? '0 : p + PTR_W'(1);
    endfunction

    assign bus.rom_addr    = fetch_pc_q;
    assign bus.instr_valid = count_q != '0;
    assign bus.instr_out   = data_mem_q[rd_q];
    assign bus.instr_pc    = pc_mem_q[rd_q];

    // Next-state: redirect flushes everything; issue only while the buffer has room for the in-flight word
    always_comb begin
        pop         = bus.instr_valid & bus.instr_ready;
        push        = req_valid_q & !redirect_i;
        issue       = fetch_en_i & !redirect_i &
                      ((CNT_W+1)'(count_q) + (CNT_W+1)'(req_valid_q) < (CNT_W+1)'(BUF_DEPTH) + (CNT_W+1)'(pop));
        fetch_pc_d  = redirect_i ? (redirect_pc_i & ~ADDR_W'(3)) :
                      issue ? fetch_pc_q + ADDR_W'(PC_STEP) : fetch_pc_q;
        req_valid_d = issue;
        req_pc_d    = issue ? fetch_pc_q : req_pc_q;
        count_d     = redirect_i ? '0 : count_q + CNT_W'(push) - CNT_W'(pop);
        rd_d        = redirect_i ? '0 : pop ? nxt(rd_q) : rd_q;
        wr_d        = redirect_i ? '0 : push ? nxt(wr_q) : wr_q;
    end

    // State registers and FIFO storage; the ROM word arriving this cycle belongs to req_pc_q
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            fetch_pc_q  <= RESET_PC;
            req_pc_q    <= '0;
            req_valid_q <= 1'b0;
            count_q     <= '0;
            rd_q        <= '0;
            wr_q        <= '0;
            for (int i = 0; i < BUF_DEPTH; i++) begin
                pc_mem_q[i]   <= '0;
                data_mem_q[i] <= '0;
            end
        end else begin
            fetch_pc_q  <= fetch_pc_d;
            req_pc_q    <= req_pc_d;
            req_valid_q <= req_valid_d;
            count_q     <= count_d;
            rd_q        <= rd_d;
            wr_q        <= wr_d;
            if (push) begin
                pc_mem_q[wr_q]   <= req_pc_q;
                data_mem_q[wr_q] <= bus.rom_data;
            end
        end
    end
endmodule

// File: tb/tb_instr_fetch_ctrl.sv
// tb_instr_fetch_ctrl: directed scenarios with a PC scoreboard checked by an independent monitor
module tb_instr_fetch_ctrl;
    logic       clk = 1'b0;
    logic       rst_n;
    logic       fetch_en;
    logic       redirect;
    logic [7:0] redirect_pc;
    int         cyc;
    int         n_cmp = 0;
    int         n_fail = 0;
    logic [31:0] rom [64];
    logic [7:0]  exp_q [$];

    instr_fetch_ctrl_if #(.ADDR_W(8), .DATA_W(32)) ifc ();

    instr_fetch_ctrl dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .fetch_en_i   (fetch_en),
        .redirect_i   (redirect),
        .redirect_pc_i(redirect_pc),
        .bus          (ifc.master)
    );

    always #5 clk = ~clk;

    // Synchronous ROM: one-cycle registered read
    always @(posedge clk) ifc.rom_data <= rom[ifc.rom_addr[7:2]];

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s (cycle %0d): got %h expected %h", name, cyc, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    // Monitor: every accepted instruction must be the next expected PC with its ROM word
    always @(negedge clk) begin
        if (rst_n && ifc.instr_valid && ifc.instr_ready) begin
            if (exp_q.size() == 0) begin
                chk("unexpected_pop_pc", {24'd0, ifc.instr_pc}, 32'hFFFF_FFFF);
            end else begin
                logic [7:0] pc;
                pc = exp_q.pop_front();
                chk("pop_pc", {24'd0, ifc.instr_pc}, {24'd0, pc});
                chk("pop_instr", ifc.instr_out, rom[pc[7:2]]);
            end
        end
    end

    initial begin
        #100000;
        $display("FAIL timeout: bench did not complete");
        $fatal(1);
    end

    initial begin
        for (int i = 0; i < 64; i++) rom[i] = 32'hE000_0000 | 32'(i);
        rom[0]  = 32'h0045_0693;
        rom[1]  = 32'h0010_0713;
        rom[2]  = 32'h00b7_6463;
        rom[13] = 32'h0027_9793;
        rom[14] = 32'h00f5_07b3;
        rst_n = 1'b0; fetch_en = 1'b1; redirect = 1'b0; redirect_pc = '0;
        ifc.instr_ready = 1'b1;
        cyc = 0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_valid", {31'd0, ifc.instr_valid}, 0);
        chk("rst_romaddr", {24'd0, ifc.rom_addr}, 0);
        chk("rst_instr_out", ifc.instr_out, 0);
        chk("rst_instr_pc", {24'd0, ifc.instr_pc}, 0);
        exp_q = '{8'h00, 8'h04, 8'h08, 8'h0C, 8'h10,
                  8'h34, 8'h38, 8'h3C,
                  8'hFC, 8'h00, 8'h04, 8'h08, 8'h0C, 8'h10,
                  8'h14, 8'h18, 8'h1C};
        rst_n = 1'b1;
        for (int k = 0; k < 35; k++) begin
            ifc.instr_ready = !(cyc inside {[3:6], 11, 12});
            redirect        = (cyc == 12) || (cyc == 17);
            redirect_pc     = (cyc == 12) ? 8'h35 : 8'hFC;
            fetch_en        = !(cyc inside {[24:29]});
            if (cyc inside {0, 1, 13, 14, 18, 19, [26:31]})
                chk("valid_low", {31'd0, ifc.instr_valid}, 0);
            if (cyc inside {2, 15, 20, 32})
                chk("valid_high", {31'd0, ifc.instr_valid}, 1);
            if (cyc == 2)  chk("first_pc", {24'd0, ifc.instr_pc}, 32'h00);
            if (cyc == 15) chk("redirect_pc", {24'd0, ifc.instr_pc}, 32'h34);
            if (cyc == 20) chk("wrap_redirect_pc", {24'd0, ifc.instr_pc}, 32'hFC);
            if (cyc == 32) chk("resume_pc", {24'd0, ifc.instr_pc}, 32'h14);
            if (cyc inside {[3:6]}) begin
                chk("hold_pc", {24'd0, ifc.instr_pc}, 32'h04);
                chk("hold_instr", ifc.instr_out, 32'h0010_0713);
                chk("hold_romaddr", {24'd0, ifc.rom_addr}, 32'h0C);
            end
            if (cyc inside {[25:30]}) chk("frozen_romaddr", {24'd0, ifc.rom_addr}, 32'h14);
            tick();
        end
        #1;
        rst_n = 1'b0;
        #1;
        chk("midrst_valid", {31'd0, ifc.instr_valid}, 0);
        chk("midrst_romaddr", {24'd0, ifc.rom_addr}, 0);
        chk("midrst_instr_pc", {24'd0, ifc.instr_pc}, 0);
        chk("midrst_queue", 32'(exp_q.size()), 0);
        repeat (2) @(posedge clk);
        @(negedge clk);
        exp_q.push_back(8'h00);
        exp_q.push_back(8'h04);
        cyc = 0;
        ifc.instr_ready = 1'b1;
        rst_n = 1'b1;
        for (int k = 0; k < 7; k++) begin
            ifc.instr_ready = cyc < 4;
            if (cyc < 2) chk("rerst_valid_low", {31'd0, ifc.instr_valid}, 0);
            if (cyc == 2) chk("rerst_first_pc", {24'd0, ifc.instr_pc}, 32'h00);
            tick();
        end
        chk("final_queue_empty", 32'(exp_q.size()), 0);
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
        $finish;
    end
endmodule
